// File: rtl/nco_multichannel_generator_if.sv
// Control and sample bus of the multichannel NCO; master drives controls, slave returns samples.
// Per-channel fields are packed with channel c at [c*W +: W].
interface nco_multichannel_generator_if #(
  parameter int NUM_CH  = 2,
  parameter int PHASE_W = 32,
  parameter int OUT_W   = 12
);
  logic                      en;
  logic [NUM_CH-1:0]         sync;
  logic                      inc_load;
  logic [NUM_CH*PHASE_W-1:0] phase_inc;
  logic [NUM_CH*PHASE_W-1:0] phase_ofs;
  logic [NUM_CH*OUT_W-1:0]   sin_out;
  logic [NUM_CH*OUT_W-1:0]   cos_out;
  logic                      valid;

  modport master (
    output en, sync, inc_load, phase_inc, phase_ofs,
    input  sin_out, cos_out, valid
  );

  modport slave (
    input  en, sync, inc_load, phase_inc, phase_ofs,
    output sin_out, cos_out, valid
  );
endinterface

// File: rtl/nco_multichannel_generator.sv
// NUM_CH phase accumulators with shadowed increments feeding a folded quarter-wave sin/cos ROM.
// Latency 3 edges from accumulator to outputs; no backpressure, a new sample pair every clock.
module nco_multichannel_generator #(
  parameter int NUM_CH     = 2,
  parameter int PHASE_W    = 32,
  parameter int OUT_W      = 12,
  parameter int LUT_ADDR_W = 10
) (
  input logic                         clk,
  input logic                         rst,
  nco_multichannel_generator_if.slave bus
);
  localparam int  MAG_W  = OUT_W - 1;
  localparam int  LUT_N  = 1 << LUT_ADDR_W;
  localparam int  DROP_W = PHASE_W - 2 - LUT_ADDR_W;
  localparam real PI     = 3.14159265358979323846;

  // Sample at bin centre so the table never holds an exact zero or needs a sign bit.
  function automatic logic [MAG_W-1:0] lut_val(input int i);
    real ang;
    real amp;
    ang = 2.0 * PI * (real'(i) + 0.5) / real'(4 * LUT_N);
    amp = real'((1 << MAG_W) - 1) * $sin(ang);
    return MAG_W'($rtoi(amp + 0.5));
  endfunction

  logic [MAG_W-1:0] rom [LUT_N];

  for (genvar i = 0; i < LUT_N; i++) begin : g_rom
    localparam logic [MAG_W-1:0] ROM_VAL = lut_val(i);
    assign rom[i] = ROM_VAL;
  end

  logic signed [OUT_W-1:0] sin_arr [NUM_CH];
  logic signed [OUT_W-1:0] cos_arr [NUM_CH];

  for (genvar c = 0; c < NUM_CH; c++) begin : g_ch
    logic [PHASE_W-1:0]      inc_q, inc_d;
    logic [PHASE_W-1:0]      acc_q, acc_d;
    logic [PHASE_W-1:0]      p_q, p_d;
    logic [MAG_W-1:0]        smag_q, smag_d, cmag_q, cmag_d;
    logic                    sneg_q, sneg_d, cneg_q, cneg_d;
    logic signed [OUT_W-1:0] sin_q, sin_d, cos_q, cos_d;
    logic [1:0]              quad, quad_c;
    logic [LUT_ADDR_W-1:0]   idx;

    always_comb begin
      inc_d = bus.inc_load ? bus.phase_inc[c*PHASE_W +: PHASE_W] : inc_q;

      // Accumulate uses the increment active before this edge's load.
      if (bus.sync[c]) begin
        acc_d = '0;
      end else if (bus.en) begin
        acc_d = acc_q + inc_q;
      end else begin
        acc_d = acc_q;
      end

      p_d = acc_q + bus.phase_ofs[c*PHASE_W +: PHASE_W];

      quad   = p_q[PHASE_W-1 -: 2];
      quad_c = quad + 2'd1;
      idx    = p_q[PHASE_W-3 -: LUT_ADDR_W];
      smag_d = quad[0]   ? rom[~idx] : rom[idx];
      sneg_d = quad[1];
      cmag_d = quad_c[0] ? rom[~idx] : rom[idx];
      cneg_d = quad_c[1];

      sin_d = sneg_q ? -$signed({1'b0, smag_q}) : $signed({1'b0, smag_q});
      cos_d = cneg_q ? -$signed({1'b0, cmag_q}) : $signed({1'b0, cmag_q});
    end

    always_ff @(posedge clk) begin
      if (rst) begin
        inc_q  <= '0;
        acc_q  <= '0;
        p_q    <= '0;
        smag_q <= '0;
        cmag_q <= '0;
        sneg_q <= 1'b0;
        cneg_q <= 1'b0;
        sin_q  <= '0;
        cos_q  <= '0;
      end else begin
        inc_q  <= inc_d;
        acc_q  <= acc_d;
        p_q    <= p_d;
        smag_q <= smag_d;
        cmag_q <= cmag_d;
        sneg_q <= sneg_d;
        cneg_q <= cneg_d;
        sin_q  <= sin_d;
        cos_q  <= cos_d;
      end
    end

    if (DROP_W > 0) begin : g_drop
      logic unused_lsb;
      assign unused_lsb = ^p_q[DROP_W-1:0];
    end

    assign sin_arr[c] = sin_q;
    assign cos_arr[c] = cos_q;
  end

  logic [NUM_CH*OUT_W-1:0] sin_flat, cos_flat;

  always_comb begin
    sin_flat = '0;
    cos_flat = '0;
    for (int c = 0; c < NUM_CH; c++) begin
      sin_flat[c*OUT_W +: OUT_W] = sin_arr[c];
      cos_flat[c*OUT_W +: OUT_W] = cos_arr[c];
    end
  end

  // Shift of constant 1 marks when the pipeline holds only post-reset data.
  logic [2:0] valid_q, valid_d;

  always_comb begin
    valid_d = {valid_q[1:0], 1'b1};
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      valid_q <= '0;
    end else begin
      valid_q <= valid_d;
    end
  end

  assign bus.sin_out = sin_flat;
  assign bus.cos_out = cos_flat;
  assign bus.valid   = valid_q[2];
endmodule

// File: doc/nco_multichannel_generator.md
Name: nco_multichannel_generator

Overview:
Parametrised successor to the single-channel NCO sine generator. Provides NUM_CH independent phase accumulators, each producing a signed quadrature pair (sin/cos) from one shared-format quarter-wave ROM with symmetry folding. Adds double-buffered frequency load, per-channel phase offset, line-start phase sync, an accumulate enable and a valid flag. It feeds the NTSC/PAL chroma modulator and the burst generator in the video output path.

Parameters:
NUM_CH, 2, number of independent NCO channels
PHASE_W, 32, accumulator and phase-offset width
OUT_W, 12, signed output sample width
LUT_ADDR_W, 10, quarter-wave ROM address width (2^LUT_ADDR_W entries)

Ports:
clk  in  1  system clock (74.25 MHz pixel clock)
rst  in  1  synchronous active-high reset
en  in  1  accumulate enable; 0 holds all accumulators
sync  in  NUM_CH  per-channel phase clear (line-start burst lock)
inc_load  in  1  strobe: copy phase_inc into the active increment registers
phase_inc  in  NUM_CH*PHASE_W  unsigned increment, ch c at bits [c*PHASE_W +: PHASE_W]
phase_ofs  in  NUM_CH*PHASE_W  unsigned phase offset per channel, same packing
sin_out  out  NUM_CH*OUT_W  signed sine per channel, packed as phase_inc
cos_out  out  NUM_CH*OUT_W  signed cosine per channel
valid  out  1  outputs reflect post-reset accumulator state

Behaviour:
- Reset (sync, active-high, all state): acc[c]=0, active_inc[c]=0, every pipeline register=0, sin_out=cos_out=0, valid=0. Asserting rst mid-operation clears all of this on the same edge; valid drops on that edge.
- Increment shadowing: changes to phase_inc have no effect until inc_load=1. On an edge with inc_load=1, active_inc <= phase_inc. The new increment is first used on the following edge's accumulate.
- Accumulator per channel, at each edge, with priority: rst, then sync[c] (acc <= 0), then en (acc <= acc + active_inc, modulo 2^PHASE_W, wrap silent), else hold.
- sync[c] clears acc[c] regardless of en. sync and inc_load on the same edge: both take effect.
- Pipeline, with fixed latency 3 from the accumulator register:
  - S1: p = acc + phase_ofs (mod 2^PHASE_W), registered; phase_ofs is sampled here.
  - S2: ROM lookups for sin and cos, registered.
  - S3: sign and negate, registered onto the outputs.
  - The acc value after edge k appears on the outputs after edge k+3.
- Folding:
  - q = p[PHASE_W-1:PHASE_W-2]; idx = the next LUT_ADDR_W bits; remaining bits truncated.
  - LUT[i] = round((2^(OUT_W-1)-1) * sin(2π(i+0.5)/2^(LUT_ADDR_W+2))). This is a half-sample offset, so there is no exact zero.
  - sin by q: 0 gives +LUT[idx]; 1 gives +LUT[~idx]; 2 gives -LUT[idx]; 3 gives -LUT[~idx].
  - cos uses quadrant q+1 (mod 4) with the same idx.
  - Output range is symmetric ±(2^(OUT_W-1)-1); -2^(OUT_W-1) is never produced.
- Hold: with en=0, outputs freeze at the last value 3 cycles later. phase_ofs changes still propagate.
- valid is a 3-stage shift of constant 1 cleared by rst. It rises on the 3rd edge after rst deasserts and is independent of en and sync.
- One ROM image is used; a true dual-port or replicated ROM per channel is acceptable as long as latency stays 3.

Test Plan:
1. Reset with NUM_CH=2, LUT_ADDR_W=10, inc=0, ofs=0 -> during rst all outputs 0 and valid=0. valid=1 on the 3rd edge after release. sin=2, cos=2047 on both channels.
2. phase_inc ch0 = 2^30, then inc_load pulse -> from 4 cycles after load, sin cycles 2, 2047, -2, -2047 and cos cycles 2047, -2, -2047, 2, repeating.
3. Change phase_inc to 207078536 without inc_load -> outputs unchanged. Pulse inc_load -> over 2000 cycles ch0 sin shows 96 ±1 positive-going sign changes (period ≈ 20.74 cycles), |value| ≤ 2047.
4. ch0 and ch1 inc=207078536, ofs ch1=2^30 -> ch1 sin equals ch0 cos on every cycle. Pulse sync[0] only -> exactly 3 edges later ch0 outputs sin=2, cos=2047 and continue advancing; ch1 is unaffected.
5. en=0 for 10 cycles mid-stream -> outputs constant from 3 cycles after en falls. Assert sync[0] while en=0 -> ch0 goes to 2/2047 and holds. Raise en -> ch0 resumes from phase 0.
6. rst pulsed for 1 cycle while running -> outputs 0 and valid 0 on that edge, active_inc=0 (outputs stay 2/2047 after valid returns) until the next inc_load.
